// File: rtl/alu_acc_pkg.sv
// Shared types for the ALU accumulator slice.
// Op codes, FSM states and data width.
package alu_acc_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_LOAD = 2'b01,
    OP_CLR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    CAPTURE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_accumulator_settle_timer.sv
// Down-counter that holds adder operands for a fixed time.
// Loads SETTLE_CYCLES-1 on start, done while the count is 0.
module settle_timer
  import alu_acc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // reload on start, otherwise count down and park at 0
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(SETTLE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_accumulator.sv
// Handshaked front-end and result capture for a ripple adder.
// Holds operands for SETTLE_CYCLES, then latches sum and flags.
module alu_accumulator
  import alu_acc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] adder_a,
  output logic [DW-1:0] adder_b,
  input  logic [DW-1:0] adder_sum,
  input  logic          adder_carryout,
  input  logic          adder_overflow,
  output logic [DW-1:0] acc,
  output logic          carry_flag,
  output logic          ovf_flag,
  output logic          ovf_sticky,
  output logic          out_valid
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if ((2 ** CNT_W) <= SETTLE_CYCLES) begin : g_bad_cnt
    $error("CNT_W too narrow for SETTLE_CYCLES");
  end

  state_e        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          sticky_q, sticky_d;
  logic          ov_q, ov_d;
  logic          accept;
  logic          start;
  logic          done;
  op_e           op;

  assign in_ready = (state_q == IDLE) && reset_n;
  assign accept   = in_valid && in_ready;
  assign op       = op_e'(in_op);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .done   (done)
  );

  // next state, operand, accumulator and flag logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    ov_d     = 1'b0;
    start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op)
            OP_ADD: begin
              a_d     = acc_q;
              b_d     = in_data;
              start   = 1'b1;
              state_d = SETTLE;
            end
            OP_LOAD: begin
              acc_d   = in_data;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
              ov_d    = 1'b1;
            end
            OP_CLR: begin
              sticky_d = 1'b0;
              ov_d     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      SETTLE: begin
        if (done) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        acc_d    = adder_sum;
        carry_d  = adder_carryout;
        ovf_d    = adder_overflow;
        sticky_d = sticky_q | adder_overflow;
        ov_d     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      ov_q     <= ov_d;
    end
  end

  assign adder_a    = a_q;
  assign adder_b    = b_q;
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;
  assign ovf_sticky = sticky_q;
  assign out_valid  = ov_q;

endmodule

// File: doc/alu_accumulator.md
Name: alu_accumulator

Overview:
- Sequential front-end and result-capture stage wrapped around the 4-bit structural ripple-carry adder.
- Accepts operations from an upstream source over a valid/ready handshake and drives the adder's a/b operands from registers.
- Holds the operands stable for a programmable number of settle cycles so the gate-delayed ripple chain resolves.
- Then captures sum, carry and overflow into an accumulator and flag registers, and pulses a result-valid strobe downstream.

Parameters:
- SETTLE_CYCLES, 4: full clock cycles operands are held before capture. Minimum 1; 0 is an elaboration error.
- CNT_W, 3: settle counter width. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream op/data valid.
- in_ready  output  1  block can accept an op. Combinational: high iff state==IDLE and reset_n high.
- in_op  input  2  00 ADD, 01 LOAD, 10 CLR_STICKY, 11 reserved.
- in_data  input  4  two's-complement operand.
- adder_a  output  4  registered operand A to adder.
- adder_b  output  4  registered operand B to adder.
- adder_sum  input  4  adder sum.
- adder_carryout  input  1  adder carry out.
- adder_overflow  input  1  adder signed overflow.
- acc  output  4  accumulator value.
- carry_flag  output  1  carry of last ADD.
- ovf_flag  output  1  overflow of last ADD.
- ovf_sticky  output  1  OR of all ADD overflows since reset/CLR_STICKY.
- out_valid  output  1  one-cycle pulse: an op completed.

Behaviour:
- Reset (async, immediate): state=IDLE. acc, adder_a, adder_b = 0. carry_flag, ovf_flag, ovf_sticky, out_valid = 0. Counter=0. Any in-flight op is dropped, with no out_valid.
- Accept: accept = in_valid & in_ready, sampled at the rising edge. in_op/in_data are only sampled on accept. in_valid while in_ready is low is ignored; upstream holds its values.
- States: IDLE, SETTLE, CAPTURE.
- IDLE, accept ADD:
  - adder_a <= acc; adder_b <= in_data; counter <= SETTLE_CYCLES-1.
  - Go to SETTLE.
- IDLE, accept LOAD:
  - acc <= in_data; carry_flag, ovf_flag <= 0; ovf_sticky unchanged; out_valid <= 1.
  - Stay IDLE.
- IDLE, accept CLR_STICKY:
  - ovf_sticky <= 0; everything else unchanged; out_valid <= 1.
  - Stay IDLE.
- IDLE, accept reserved (11): consumed as a no-op, no out_valid.
- SETTLE:
  - counter==0 -> CAPTURE; otherwise decrement.
  - adder_a/adder_b held constant.
- CAPTURE (one cycle, at its closing edge):
  - acc <= adder_sum; carry_flag <= adder_carryout; ovf_flag <= adder_overflow.
  - ovf_sticky <= ovf_sticky | adder_overflow; out_valid <= 1.
  - Go to IDLE.
- out_valid: registered and high for exactly one cycle. It is deasserted at the next edge unless another LOAD/CLR completes.
- ADD timing with accept at edge 0:
  - SETTLE covers edges 1..SETTLE_CYCLES.
  - Capture happens at edge SETTLE_CYCLES+1; out_valid is high in the following cycle.
  - in_ready is high again after edge SETTLE_CYCLES+1, so the earliest next accept is edge SETTLE_CYCLES+2.
- Throughput: ADD = 1 per SETTLE_CYCLES+2 cycles; LOAD/CLR = 1 per cycle.
- Width rules: 4-bit two's-complement with modular wrap. The adder's carry-in is fixed at 0, so there is no subtract; upstream negates via a LOAD/ADD sequence.
- Integration: SETTLE_CYCLES*Tclk must exceed the adder's worst-case ripple delay (50-unit gates, carry chain through 4 stages). The integrator sets this.

Decomposition:
- Shared package alu_acc_pkg:
  - op encoding constants OP_ADD, OP_LOAD, OP_CLR, OP_RSVD;
  - state encoding IDLE/SETTLE/CAPTURE;
  - data width constant 4.
- One natural sub-module: settle_timer. It loads SETTLE_CYCLES-1 on start, counts down and asserts done at 0, with async active-low reset.
- FSM and flag registers stay in alu_accumulator.
- The adder is instantiated at the level above, not inside this block.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately, in_ready=0 during reset and 1 after release.
- LOAD 4'b0111, then ADD 4'b0001 (SETTLE_CYCLES=4, accept at edge 0):
  - acc=4'b1000, ovf_flag=1, ovf_sticky=1, carry_flag=0, captured at edge 5;
  - out_valid high between edges 5 and 6 only.
- LOAD 4'b1111, ADD 4'b0001 -> acc=0, carry_flag=1, ovf_flag=0, ovf_sticky stays 1; then CLR_STICKY -> ovf_sticky=0, acc unchanged.
- Backpressure: two ADD +3 held back-to-back from acc=1 -> accepts at edges 0 and 6, acc=4 then 7, exactly two out_valid pulses.
- Reset pulse during SETTLE (edge 2 of ADD) -> no capture, no out_valid, acc=0, state IDLE.
- Operand stability: a bench monitor checks adder_a/adder_b do not change from accept+1 through capture for 200 random ops, against the real structural adder at SETTLE_CYCLES=4.
